// File: rtl/uart_defs_pkg.sv
// Constants shared by the UART receiver, transmitter and the RX stream buffer.
// The AXIS widths here keep the UART side and the stream side agreeing on beat layout.
package uart_defs;

   localparam int         UART_DATA_BITS = 8;
   localparam logic [7:0] UART_EOP_CHAR  = 8'h0A;

   localparam int AXIS_TDATA_W = UART_DATA_BITS;
   localparam int AXIS_TLAST_W = 1;
   localparam int AXIS_BEAT_W  = AXIS_TDATA_W + AXIS_TLAST_W;

endpackage

// File: rtl/uart_rx_axis_fifo_sync_fifo.sv
// Single-clock first-word-fall-through FIFO with an explicit occupancy counter.
// A push into a full FIFO is accepted only when a pop frees the head slot in the same cycle.
module sync_fifo #(
   parameter int WIDTH   = 9,
   parameter int DEPTH   = 16,
   localparam int PTR_W   = $clog2(DEPTH),
   localparam int LEVEL_W = $clog2(DEPTH) + 1
) (
   input  logic               clk,
   input  logic               rst_n,
   input  logic               push,
   input  logic               pop,
   input  logic [WIDTH-1:0]   wdata,
   output logic [WIDTH-1:0]   rdata,
   output logic               full,
   output logic               empty,
   output logic [LEVEL_W-1:0] level
);

   logic [WIDTH-1:0] mem [DEPTH];
   logic [PTR_W-1:0] wr_ptr;
   logic [PTR_W-1:0] rd_ptr;
   logic             wr_en;
   logic             rd_en;

   assign full  = (level == LEVEL_W'(DEPTH));
   assign empty = (level == '0);
   assign rd_en = pop && !empty;
   assign wr_en = push && (!full || rd_en);
   assign rdata = mem[rd_ptr];

   // NOTE: storage has no reset; only pointers and level decide what is valid, so mem stays plain RAM.
   always_ff @(posedge clk) begin
      if (wr_en) mem[wr_ptr] <= wdata;
   end

   // NOTE: state registers use non-blocking assignments so every update sees pre-edge values.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         level  <= '0;
      end else begin
         if (wr_en) wr_ptr <= wr_ptr + PTR_W'(1);
         if (rd_en) rd_ptr <= rd_ptr + PTR_W'(1);
         if (wr_en && !rd_en)      level <= level + LEVEL_W'(1);
         else if (rd_en && !wr_en) level <= level - LEVEL_W'(1);
      end
   end

endmodule

// File: rtl/uart_rx_axis_fifo.sv
// Buffers bytes from the UART receiver and presents them as an AXI-Stream master,
// tagging the end-of-packet character with tlast and flagging dropped bytes.
module uart_rx_axis_fifo
   import uart_defs::*;
#(
   parameter int                   DATA_BITS = UART_DATA_BITS,
   parameter int                   DEPTH     = 16,
   parameter bit                   EOP_EN    = 1'b1,
   parameter logic [DATA_BITS-1:0] EOP_CHAR  = DATA_BITS'(UART_EOP_CHAR),
   localparam int                  LEVEL_W   = $clog2(DEPTH) + 1
) (
   input  logic                 clk,
   input  logic                 rst_n,
   input  logic [DATA_BITS-1:0] rx_data,
   input  logic                 rx_valid,
   output logic [DATA_BITS-1:0] m_axis_tdata,
   output logic                 m_axis_tvalid,
   input  logic                 m_axis_tready,
   output logic                 m_axis_tlast,
   output logic                 overflow,
   input  logic                 overflow_clr,
   output logic [LEVEL_W-1:0]   level
);

   localparam int ENTRY_W = DATA_BITS + AXIS_TLAST_W;

   logic               fifo_full;
   logic               fifo_empty;
   logic               push;
   logic               pop;
   logic               ovf_set;
   logic               eop;
   logic [ENTRY_W-1:0] wdata;
   logic [ENTRY_W-1:0] rdata;

   assign eop   = EOP_EN && (rx_data == EOP_CHAR);
   assign wdata = {eop, rx_data};

   // tvalid comes from registered occupancy only, so tready never reaches it combinationally.
   assign m_axis_tvalid               = !fifo_empty;
   assign pop                         = m_axis_tvalid && m_axis_tready;
   assign {m_axis_tlast, m_axis_tdata} = rdata;

   assign push    = rx_valid && (!fifo_full || pop);
   assign ovf_set = rx_valid && fifo_full && !pop;

   // A drop in the same cycle as a clear keeps the flag set.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n)            overflow <= 1'b0;
      else if (ovf_set)      overflow <= 1'b1;
      else if (overflow_clr) overflow <= 1'b0;
   end

   sync_fifo #(
      .WIDTH (ENTRY_W),
      .DEPTH (DEPTH)
   ) u_fifo (
      .clk   (clk),
      .rst_n (rst_n),
      .push  (push),
      .pop   (pop),
      .wdata (wdata),
      .rdata (rdata),
      .full  (fifo_full),
      .empty (fifo_empty),
      .level (level)
   );

endmodule

// File: tb/tb_uart_rx_axis_fifo.sv
// Scoreboard bench: stimulus pushes expected beats into queues, a negedge monitor pops and compares.
// A second instance with EOP tagging disabled sees the same stimulus.
module tb_uart_rx_axis_fifo;

   localparam int DEPTH   = 16;
   localparam int LEVEL_W = $clog2(DEPTH) + 1;

   logic               clk = 1'b0;
   logic               rst_n;
   logic [7:0]         rx_data;
   logic               rx_valid;
   logic               m_axis_tready;
   logic               overflow_clr;

   logic [7:0]         tdata1, tdata2;
   logic               tvalid1, tvalid2;
   logic               tlast1, tlast2;
   logic               ovf1, ovf2;
   logic [LEVEL_W-1:0] level1, level2;

   logic [8:0] exp_q1[$];
   logic [8:0] exp_q2[$];
   logic       pend    = 1'b0;
   logic       exp_ovf = 1'b0;
   logic       hold    = 1'b0;
   logic [7:0] hold_d;
   logic       hold_l;

   int passed = 0;
   int total  = 0;

   always #5 clk = ~clk;

   uart_rx_axis_fifo #(.DATA_BITS(8), .DEPTH(DEPTH), .EOP_EN(1'b1), .EOP_CHAR(8'h0A)) dut (
      .clk(clk), .rst_n(rst_n), .rx_data(rx_data), .rx_valid(rx_valid),
      .m_axis_tdata(tdata1), .m_axis_tvalid(tvalid1), .m_axis_tready(m_axis_tready),
      .m_axis_tlast(tlast1), .overflow(ovf1), .overflow_clr(overflow_clr), .level(level1)
   );

   uart_rx_axis_fifo #(.DATA_BITS(8), .DEPTH(DEPTH), .EOP_EN(1'b0), .EOP_CHAR(8'h0A)) dut_noeop (
      .clk(clk), .rst_n(rst_n), .rx_data(rx_data), .rx_valid(rx_valid),
      .m_axis_tdata(tdata2), .m_axis_tvalid(tvalid2), .m_axis_tready(m_axis_tready),
      .m_axis_tlast(tlast2), .overflow(ovf2), .overflow_clr(overflow_clr), .level(level2)
   );

   task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
      total++;
      if (got === exp) passed++;
      else $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, got, exp, $time);
   endtask

   // Drive one clock of stimulus, update the reference queues, and return at posedge+1 idle.
   task automatic cycle(input logic v, input logic [7:0] d, input logic rdy, input logic clr);
      int   cnt;
      logic drop;
      cnt  = exp_q1.size();
      drop = 1'b0;
      rx_valid      = v;
      rx_data       = d;
      m_axis_tready = rdy;
      overflow_clr  = clr;
      if (v) begin
         if (cnt < DEPTH || (cnt > 0 && rdy)) begin
            exp_q1.push_back({d == 8'h0A, d});
            exp_q2.push_back({1'b0, d});
            pend = 1'b1;
         end else begin
            drop = 1'b1;
         end
      end
      if (drop)     exp_ovf = 1'b1;
      else if (clr) exp_ovf = 1'b0;
      @(posedge clk);
      #1;
      rx_valid     = 1'b0;
      overflow_clr = 1'b0;
      pend         = 1'b0;
   endtask

   task automatic check_state(input string name);
      check({name, "_level"},  level1,  exp_q1.size());
      check({name, "_level2"}, level2,  exp_q2.size());
      check({name, "_tvalid"}, tvalid1, exp_q1.size() != 0);
      check({name, "_ovf"},    ovf1,    exp_ovf);
      check({name, "_ovf2"},   ovf2,    exp_ovf);
   endtask

   always @(negedge clk) begin
      if (rst_n) begin
         check("mon_tvalid",  tvalid1, (exp_q1.size() - int'(pend)) != 0);
         check("mon_tvalid2", tvalid2, (exp_q2.size() - int'(pend)) != 0);
         if (hold) begin
            check("hold_tdata", tdata1, hold_d);
            check("hold_tlast", tlast1, hold_l);
         end
         if (tvalid1 && exp_q1.size() != 0) begin
            check("beat_tdata", tdata1, exp_q1[0][7:0]);
            check("beat_tlast", tlast1, exp_q1[0][8]);
            if (m_axis_tready) void'(exp_q1.pop_front());
         end
         if (tvalid2 && exp_q2.size() != 0) begin
            check("beat2_tdata", tdata2, exp_q2[0][7:0]);
            check("beat2_tlast", tlast2, exp_q2[0][8]);
            if (m_axis_tready) void'(exp_q2.pop_front());
         end
         hold   = tvalid1 && !m_axis_tready;
         hold_d = tdata1;
         hold_l = tlast1;
      end
   end

   initial begin
      logic v;
      rst_n = 1'b0; rx_valid = 1'b0; rx_data = '0; m_axis_tready = 1'b0; overflow_clr = 1'b0;
      repeat (2) @(posedge clk);
      #1;
      check_state("reset");

      // first edge after release takes the push
      rst_n = 1'b1;
      cycle(1'b1, 8'h41, 1'b1, 1'b0);
      check_state("single_beat");
      check("single_tdata", tdata1, 8'h41);
      check("single_tlast", tlast1, 1'b0);
      cycle(1'b0, 8'h00, 1'b1, 1'b0);
      check_state("single_gone");

      cycle(1'b1, 8'h48, 1'b1, 1'b0);
      cycle(1'b1, 8'h0A, 1'b1, 1'b0);
      check("eop_tlast",   tlast1, 1'b1);
      check("noeop_tlast", tlast2, 1'b0);
      repeat (2) cycle(1'b0, 8'h00, 1'b1, 1'b0);
      check_state("eop_done");

      cycle(1'b1, 8'h11, 1'b0, 1'b0);
      cycle(1'b1, 8'h22, 1'b0, 1'b0);
      cycle(1'b1, 8'h33, 1'b0, 1'b0);
      repeat (2) cycle(1'b0, 8'h00, 1'b0, 1'b0);
      check_state("bp_three");
      check("bp_head", tdata1, 8'h11);
      repeat (3) cycle(1'b0, 8'h00, 1'b1, 1'b0);
      check_state("bp_drained");

      for (int i = 0; i < 17; i++) cycle(1'b1, 8'(8'h80 + i), 1'b0, 1'b0);
      check_state("ovf_full");
      check("ovf_set", ovf1, 1'b1);
      cycle(1'b1, 8'h77, 1'b0, 1'b1);
      check_state("ovf_set_wins");
      cycle(1'b0, 8'h00, 1'b0, 1'b1);
      check_state("ovf_cleared");

      cycle(1'b1, 8'hA5, 1'b1, 1'b0);
      check_state("full_simul");
      repeat (20) cycle(1'b0, 8'h00, 1'b1, 1'b0);
      check_state("full_drained");

      for (int i = 0; i < 40; ) begin
         v = ($urandom_range(0, 3) != 0);
         if (v) i++;
         cycle(v, 8'($urandom), 1'($urandom_range(0, 1)), 1'b0);
      end
      repeat (24) cycle(1'b0, 8'h00, 1'b1, 1'b0);
      cycle(1'b0, 8'h00, 1'b0, 1'b1);
      check_state("stream_drained");

      for (int i = 0; i < 5; i++) cycle(1'b1, 8'(8'h50 + i), 1'b0, 1'b0);
      check_state("pre_reset");
      #1 rst_n = 1'b0;
      #1;
      check("rst_tvalid", tvalid1, 1'b0);
      check("rst_level",  level1,  '0);
      check("rst_level2", level2,  '0);
      check("rst_ovf",    ovf1,    1'b0);
      exp_q1.delete();
      exp_q2.delete();
      exp_ovf = 1'b0;
      hold    = 1'b0;
      @(posedge clk);
      #1 rst_n = 1'b1;
      cycle(1'b1, 8'h5A, 1'b0, 1'b0);
      check_state("post_reset");
      check("post_reset_tdata", tdata1, 8'h5A);
      repeat (3) cycle(1'b0, 8'h00, 1'b1, 1'b0);
      check_state("final");

      $display("%0d/%0d checks passed", passed, total);
      $finish;
   end

endmodule
